// File: rtl/unpacker.sv
// Byte-stream unpacker: packed memory words enter a small byte FIFO, and each
// output sample is rebuilt from the K oldest bytes, where K is the number of
// groups left enabled by the configuration mask. Disabled groups read as zero.
module unpacker #(
  parameter int INPUT = 4,
  parameter int MEM   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_stb_i,
  input  logic [INPUT-1:0]   cfg_i,
  input  logic               w_stb_i,
  output logic               w_rdy_o,
  input  logic [MEM*8-1:0]   w_i,
  output logic               s_stb_o,
  input  logic               s_rdy_i,
  output logic [INPUT*8-1:0] s_o
);

  localparam int CAP = INPUT + MEM - 1;
  localparam int CW  = $clog2(CAP + 1);
  localparam int KW  = $clog2(INPUT + 1);

  // Number of enabled groups, i.e. bytes consumed per sample.
  function automatic logic [KW-1:0] count_enabled(input logic [INPUT-1:0] mask);
    logic [KW-1:0] n;
    n = '0;
    for (int g = 0; g < INPUT; g++) begin
      if (!mask[g]) n = n + KW'(1);
    end
    return n;
  endfunction

  logic [7:0]         byte_p0 [CAP];
  logic [7:0]         byte_n  [CAP];
  logic [CW-1:0]      cnt_p0;
  logic [CW-1:0]      cnt_n;
  logic [INPUT-1:0]   cfg_p0;
  logic               vld_p1;
  logic [INPUT*8-1:0] samp_p1;
  logic [INPUT*8-1:0] samp_n;
  logic [KW-1:0]      k_en;
  logic               slot_free;
  logic               accept;
  logic               extract;

  assign k_en      = count_enabled(cfg_p0);
  // Ready only looks at the registered fill level, so it never combinationally
  // follows the downstream handshake; at most MEM bytes land on top of INPUT-1.
  assign w_rdy_o   = !rst_i && (cnt_p0 < CW'(INPUT));
  assign slot_free = !vld_p1 || s_rdy_i;
  assign accept    = w_stb_i && w_rdy_o;
  assign extract   = slot_free && (k_en != '0) && (cnt_p0 >= CW'(k_en));

  assign s_stb_o   = vld_p1;
  assign s_o       = samp_p1;

  // Steer the oldest bytes to enabled groups, highest enabled index first.
  always_comb begin
    int j;
    samp_n = '0;
    j = 0;
    for (int g = INPUT - 1; g >= 0; g--) begin
      if (!cfg_p0[g]) begin
        if (j < CAP) samp_n[g*8 +: 8] = byte_p0[j];
        j++;
      end
    end
  end

  // Next FIFO contents: drop the extracted head, then append the new word
  // behind whatever remains (oldest byte of the word first).
  always_comb begin
    int k;
    int base;
    k    = int'(k_en);
    base = int'(cnt_p0);
    for (int i = 0; i < CAP; i++) byte_n[i] = byte_p0[i];
    if (extract) begin
      for (int i = 0; i < CAP; i++) begin
        if (i + k < CAP) byte_n[i] = byte_p0[i + k];
      end
      base = base - k;
    end
    if (accept && (k != 0)) begin
      for (int i = 0; i < CAP; i++) begin
        if ((i >= base) && (i < base + MEM)) byte_n[i] = w_i[(MEM - 1 - (i - base))*8 +: 8];
      end
      cnt_n = CW'(base + MEM);
    end else begin
      cnt_n = CW'(base);
    end
  end

  // Stage p0: byte storage; validity is carried by cnt_p0 so contents need no reset.
  always_ff @(posedge clk_i) begin
    byte_p0 <= byte_n;
  end

  // Stage p0/p1 control: fill level, mask, and the one-entry output slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_p0  <= '0;
      cfg_p0  <= '0;
      vld_p1  <= 1'b0;
      samp_p1 <= '0;
    end else if (cfg_stb_i) begin
      cfg_p0  <= cfg_i;
      cnt_p0  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      cnt_p0 <= cnt_n;
      if (extract) begin
        samp_p1 <= samp_n;
        vld_p1  <= 1'b1;
      end else if (s_rdy_i) begin
        vld_p1  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unpacker.sv
// Bench for unpacker: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_unpacker;

  logic        clk;
  logic        rst;
  logic        cfg_stb;
  logic [3:0]  cfg_in;
  logic        w_stb;
  logic        w_rdy;
  logic [31:0] w_in;
  logic        s_stb;
  logic        s_rdy;
  logic [31:0] s_out;

  int n_cmp = 0;
  int n_err = 0;

  unpacker #(.INPUT(4), .MEM(4)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_stb_i(cfg_stb), .cfg_i(cfg_in),
    .w_stb_i(w_stb), .w_rdy_o(w_rdy), .w_i(w_in),
    .s_stb_o(s_stb), .s_rdy_i(s_rdy), .s_o(s_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: byte queue, mask, output slot.
  logic [7:0]  m_q[$];
  logic [3:0]  m_cfg;
  logic        m_stb;
  logic [31:0] m_so;
  int          m_k;
  bit          m_acc;
  bit          m_ext;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_cfg = 4'b0000;
      m_stb = 1'b0;
      m_so  = 32'h0;
    end else if (cfg_stb) begin
      m_cfg = cfg_in;
      m_q.delete();
      m_stb = 1'b0;
    end else begin
      m_k = 0;
      for (int g = 0; g < 4; g++) if (!m_cfg[g]) m_k++;
      m_acc = w_stb && (m_q.size() < 4);
      m_ext = (!m_stb || s_rdy) && (m_k > 0) && (m_q.size() >= m_k);
      if (m_ext) begin
        for (int g = 3; g >= 0; g--) begin
          if (!m_cfg[g]) m_so[g*8 +: 8] = m_q.pop_front();
          else           m_so[g*8 +: 8] = 8'h00;
        end
        m_stb = 1'b1;
      end else if (m_stb && s_rdy) begin
        m_stb = 1'b0;
      end
      if (m_acc && (m_k > 0))
        for (int b = 3; b >= 0; b--) m_q.push_back(w_in[b*8 +: 8]);
    end
  end

  // Compare process plus a log of samples handed downstream.
  logic [31:0] got_q[$];

  always @(negedge clk) begin
    chk("w_rdy", {31'b0, w_rdy}, {31'b0, (!rst && (m_q.size() < 4))});
    chk("s_stb", {31'b0, s_stb}, {31'b0, m_stb});
    if (m_stb || rst) chk("s_o", s_out, m_so);
    if (s_stb && s_rdy && !rst) got_q.push_back(s_out);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input logic [3:0] v);
    cfg_stb = 1'b1;
    cfg_in  = v;
    tick();
    cfg_stb = 1'b0;
    cfg_in  = 4'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    w_stb = 1'b1;
    w_in  = w;
    t = 0;
    while (!w_rdy && t < 50) begin
      tick();
      t++;
    end
    if (!w_rdy) chk("send_timeout", 32'd0, 32'd1);
    tick();
    w_stb = 1'b0;
    w_in  = $urandom;
  endtask

  task automatic drain();
    int t;
    s_rdy = 1'b1;
    t = 0;
    while ((m_q.size() != 0 || m_stb) && t < 50) begin
      tick();
      t++;
    end
    if (m_q.size() != 0 || m_stb) chk("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  logic [31:0] sent[$];
  logic [31:0] words[3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_stb = 1'b0; cfg_in = 4'b0; w_stb = 1'b0; w_in = 32'h0; s_rdy = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_w_rdy", {31'b0, w_rdy}, 32'd0);
    chk("rst_s_stb", {31'b0, s_stb}, 32'd0);
    chk("rst_s_o", s_out, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_w_rdy", {31'b0, w_rdy}, 32'd1);
    chk("post_rst_s_stb", {31'b0, s_stb}, 32'd0);

    // Full mask passthrough and two-edge latency.
    got_q.delete();
    s_rdy = 1'b1;
    send_word(32'hA1B2C3D4);
    chk("lat_before", {31'b0, s_stb}, 32'd0);
    tick();
    chk("lat_after", {31'b0, s_stb}, 32'd1);
    chk("lat_data", s_out, 32'hA1B2C3D4);
    drain();
    chk("t31_n", got_q.size(), 32'd1);
    if (got_q.size() >= 1) chk("t31_s0", got_q[0], 32'hA1B2C3D4);

    // Two groups enabled: one word yields two samples.
    set_cfg(4'b1100);
    got_q.delete();
    send_word(32'h11223344);
    drain();
    chk("t32_n", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      chk("t32_s0", got_q[0], 32'h00001122);
      chk("t32_s1", got_q[1], 32'h00003344);
    end

    // Three groups enabled, words streamed back to back.
    set_cfg(4'b1000);
    got_q.delete();
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    drain();
    chk("t33_n", got_q.size(), 32'd4);
    if (got_q.size() >= 4) begin
      chk("t33_s0", got_q[0], 32'h00010203);
      chk("t33_s1", got_q[1], 32'h00040506);
      chk("t33_s2", got_q[2], 32'h00070809);
      chk("t33_s3", got_q[3], 32'h000A0B0C);
    end

    // Downstream stall: hold output, back-pressure input, lose nothing.
    set_cfg(4'b0000);
    got_q.delete();
    sent.delete();
    words[0] = 32'hDEAD0001; words[1] = 32'hBEEF0002; words[2] = 32'hCAFE0003;
    s_rdy = 1'b0;
    w_stb = 1'b1;
    w_in  = words[0];
    for (int c = 0; c < 6; c++) begin
      if (w_rdy && sent.size() < 3) begin
        sent.push_back(w_in);
        tick();
        if (sent.size() < 3) w_in = words[sent.size()];
        else w_stb = 1'b0;
      end else begin
        tick();
      end
    end
    w_stb = 1'b0;
    chk("t34_w_rdy", {31'b0, w_rdy}, 32'd0);
    chk("t34_s_stb", {31'b0, s_stb}, 32'd1);
    chk("t34_s_o", s_out, 32'hDEAD0001);
    drain();
    chk("t34_n", got_q.size(), sent.size());
    for (int i = 0; i < sent.size() && i < got_q.size(); i++)
      chk("t34_word", got_q[i], sent[i]);

    // Flush with bytes buffered and a sample pending.
    set_cfg(4'b1100);
    s_rdy = 1'b0;
    send_word(32'h66778899);
    tick();
    chk("t35_pre_stb", {31'b0, s_stb}, 32'd1);
    set_cfg(4'b0000);
    chk("t35_post_stb", {31'b0, s_stb}, 32'd0);
    chk("t35_post_rdy", {31'b0, w_rdy}, 32'd1);
    got_q.delete();
    s_rdy = 1'b1;
    send_word(32'h5A6B7C8D);
    drain();
    chk("t35_n", got_q.size(), 32'd1);
    if (got_q.size() >= 1) chk("t35_s0", got_q[0], 32'h5A6B7C8D);

    // Asynchronous reset mid-stream.
    set_cfg(4'b1110);
    s_rdy = 1'b0;
    w_stb = 1'b1;
    w_in  = 32'h12345678;
    tick(); tick(); tick();
    #1;
    rst = 1'b1;
    #1;
    chk("t36_s_stb", {31'b0, s_stb}, 32'd0);
    chk("t36_s_o", s_out, 32'h0);
    chk("t36_w_rdy", {31'b0, w_rdy}, 32'd0);
    w_stb = 1'b0;
    @(negedge clk); #3;
    rst = 1'b0;
    tick();
    chk("t36_rdy_after", {31'b0, w_rdy}, 32'd1);
    got_q.delete();
    s_rdy = 1'b1;
    send_word(32'h0F1E2D3C);
    drain();
    chk("t36_n", got_q.size(), 32'd1);
    if (got_q.size() >= 1) chk("t36_cfg_default", got_q[0], 32'h0F1E2D3C);

    // Randomized traffic with occasional reconfiguration.
    set_cfg(4'($urandom));
    for (int c = 0; c < 4000; c++) begin
      w_stb   = ($urandom % 4) != 0;
      w_in    = $urandom;
      s_rdy   = ($urandom % 3) != 0;
      cfg_stb = ($urandom % 150) == 0;
      cfg_in  = 4'($urandom);
      tick();
    end
    cfg_stb = 1'b0;
    w_stb   = 1'b0;
    s_rdy   = 1'b1;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 SHALL have parameter INPUT, default 4: bytes per sample (channel groups).
REQ-002 SHALL have parameter MEM, default 4: bytes per packed memory word.
REQ-003 SHALL have port clk_i  input  1  system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; reset is asynchronous and active-high.
REQ-005 SHALL have port cfg_stb_i  input  1  cfg_i valid, load configuration.
REQ-006 SHALL have port cfg_i  input  INPUT  per-group disable mask (1 = group disabled).
REQ-007 SHALL have port w_stb_i  input  1  packed word valid.
REQ-008 SHALL have port w_rdy_o  output  1  unpacker accepts packed word.
REQ-009 SHALL have port w_i  input  MEM x 8  packed word; byte MEM-1 oldest.
REQ-010 SHALL have port s_stb_o  output  1  reconstructed sample valid.
REQ-011 SHALL have port s_rdy_i  input  1  downstream accepts sample.
REQ-012 SHALL have port s_o  output  INPUT x 8  reconstructed sample.

Function
REQ-013 SHALL keep a byte buffer of capacity CAP = INPUT+MEM-1 bytes plus a count cnt (0..CAP), FIFO ordered.
REQ-014 SHALL define K = number of zero bits in the stored cfg (enabled groups), 0..INPUT.
REQ-015 SHALL drive w_rdy_o = 1 iff rst_i low and cnt <= INPUT-1; w_rdy_o depends only on registered state, never combinationally on s_rdy_i or w_stb_i.
REQ-016 SHALL accept a word on an edge where w_stb_i & w_rdy_o, appending w_i[MEM-1] first, w_i[0] last; cnt += MEM.
REQ-017 SHALL, when K = 0, accept words with w_rdy_o = 1 and discard them; cnt stays 0, no sample is produced.
REQ-018 SHALL treat the output register as a one-entry slot, free when s_stb_o = 0 or s_rdy_i = 1.
REQ-019 SHALL, on an edge where the slot is free, K > 0 and cnt >= K, remove the K oldest bytes, load s_o and set s_stb_o = 1.
REQ-020 SHALL assign removed bytes oldest-first to enabled groups in descending index order (highest enabled index gets oldest byte); disabled groups SHALL read 8'h00.
REQ-021 SHALL clear s_stb_o on an edge where s_stb_o & s_rdy_i and no new sample is loaded.
REQ-022 SHALL hold s_o and s_stb_o stable while s_stb_o = 1 and s_rdy_i = 0.
REQ-023 SHALL allow accept and extract on the same edge: cnt_next = cnt + MEM·accept − K·extract; extract decision uses pre-edge cnt only, so a word accepted this edge is extractable no earlier than the next edge.
REQ-024 SHALL give latency: word accepted at edge N completing a sample -> s_stb_o = 1 after edge N+1 (slot free).
REQ-025 SHALL never overflow: cnt <= CAP on every edge; never underflow: extraction only when cnt >= K.
REQ-026 SHALL on a cfg_stb_i edge load cfg <= cfg_i, clear cnt to 0 and clear s_stb_o; any same-edge accept or extract is dropped (flush wins).
REQ-027 SHALL ignore w_i content and s_rdy_i when the respective handshake is not active.

Reset
REQ-028 SHALL while rst_i is high (asynchronously) force cnt = 0, cfg = 0 (all enabled), s_stb_o = 0, s_o = 0, w_rdy_o = 0.
REQ-029 SHALL after rst_i deassertion present w_rdy_o = 1 and s_stb_o = 0 until a word is accepted.
REQ-030 SHALL discard any partial sample and buffered bytes on reset mid-operation.

Verification (INPUT=4, MEM=4)
REQ-031 SHALL check cfg=4'b0000, word w_i[3..0]=A1,B2,C3,D4 -> one sample s_o[3..0]=A1,B2,C3,D4, two edges after accept.
REQ-032 SHALL check cfg=4'b1100, word 11,22,33,44 -> samples {00,00,11,22} then {00,00,33,44} on consecutive cycles with s_rdy_i=1.
REQ-033 SHALL check cfg=4'b1000, words 01..04, 05..08, 09..0C streamed -> samples {00,01,02,03},{00,04,05,06},{00,07,08,09},{00,0A,0B,0C}; cnt never exceeds 7.
REQ-034 SHALL check s_rdy_i=0 for 6 cycles with words pending -> s_o/s_stb_o constant, w_rdy_o falls to 0 once cnt >= 4, no byte lost after s_rdy_i=1.
REQ-035 SHALL check cfg_stb_i with 2 bytes buffered and s_stb_o=1 -> next cycle s_stb_o=0, cnt=0, following word unpacked with new mask.
REQ-036 SHALL check rst_i pulse mid-stream asynchronous to clk_i -> outputs zero immediately, w_rdy_o=1 after release, cfg back to 4'b0000.
